opb_master: RTL and testbench

OPB_MASTER -- requirements
Module: opb_master

---
 rtl/opb_pkg.sv | 17 +
 rtl/opb_master.sv | 187 ++++++++++++++++++
 tb/tb_opb_master.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/opb_pkg.sv
// Shared definitions for the OPB bus master: FSM state encoding and the
// default byte stride between burst beats.
package opb_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RD_ISSUE = 3'd1,
        RD_CAPT  = 3'd2,
        RD_HOLD  = 3'd3,
        WR_WAIT  = 3'd4,
        WR_ISSUE = 3'd5,
        WR_RSP   = 3'd6
    } opb_state_e;

    localparam int unsigned OPB_ADDR_STEP = 4;

endpackage

// File: rtl/opb_master.sv
// Command-driven OPB burst master: turns one read/write burst command into
// single-cycle RE/WE pulses on the decoder bus and returns a response stream.
module opb_master
    import opb_pkg::*;
#(
    parameter int          LEN_W     = 8,
    parameter int unsigned ADDR_STEP = OPB_ADDR_STEP
) (
    input  logic             OPB_CLK,
    input  logic             OPB_RST_N,
    input  logic             CMD_VALID,
    output logic             CMD_READY,
    input  logic             CMD_RNW,
    input  logic [31:0]      CMD_ADDR,
    input  logic [LEN_W-1:0] CMD_LEN,
    input  logic             WD_VALID,
    output logic             WD_READY,
    input  logic [31:0]      WD_DATA,
    output logic             RSP_VALID,
    input  logic             RSP_READY,
    output logic [31:0]      RSP_RDATA,
    output logic             RSP_LAST,
    output logic             OPB_RE,
    output logic             OPB_WE,
    output logic [31:0]      OPB_ADDR,
    output logic [31:0]      OPB_DI,
    input  logic [31:0]      OPB_DO,
    output logic             BUSY
);

    localparam logic [31:0] STEP = 32'(ADDR_STEP);

    opb_state_e       state_q, state_d;
    logic             rnw_q, rnw_d;
    logic [31:0]      addr_q, addr_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic [31:0]      opb_addr_q, opb_addr_d;
    logic [31:0]      opb_di_q, opb_di_d;
    logic             opb_re_q, opb_re_d;
    logic             opb_we_q, opb_we_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [31:0]      rsp_rdata_q, rsp_rdata_d;
    logic             rsp_last_q, rsp_last_d;
    logic             cmd_ready_q, cmd_ready_d;
    logic             wd_ready_q, wd_ready_d;
    logic             busy_q, busy_d;

    logic             last_beat;
    logic             beat_done;

    assign last_beat = (cnt_q == '0);
    // A read beat ends when its response is taken; a write beat ends with its WE.
    assign beat_done = ((state_q == RD_HOLD) && rsp_valid_q && RSP_READY) ||
                       (state_q == WR_ISSUE);

    always_comb begin
        state_d     = state_q;
        rnw_d       = rnw_q;
        addr_d      = addr_q;
        cnt_d       = cnt_q;
        opb_addr_d  = opb_addr_q;
        opb_di_d    = opb_di_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_last_d  = rsp_last_q;

        case (state_q)
            IDLE: begin
                if (cmd_ready_q && CMD_VALID) begin
                    rnw_d  = CMD_RNW;
                    addr_d = CMD_ADDR;
                    cnt_d  = CMD_LEN;
                    if (CMD_RNW) begin
                        opb_addr_d = CMD_ADDR;
                        state_d    = RD_ISSUE;
                    end else begin
                        state_d    = WR_WAIT;
                    end
                end
            end
            RD_ISSUE: state_d = RD_CAPT;
            RD_CAPT: begin
                rsp_valid_d = 1'b1;
                rsp_rdata_d = OPB_DO;
                rsp_last_d  = last_beat;
                state_d     = RD_HOLD;
            end
            RD_HOLD: begin
                if (rsp_valid_q && RSP_READY) begin
                    rsp_valid_d = 1'b0;
                    rsp_last_d  = 1'b0;
                end
            end
            WR_WAIT: begin
                if (wd_ready_q && WD_VALID) begin
                    opb_di_d   = WD_DATA;
                    opb_addr_d = addr_q;
                    state_d    = WR_ISSUE;
                end
            end
            WR_ISSUE: begin
                if (last_beat) begin
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = '0;
                    rsp_last_d  = 1'b1;
                    state_d     = WR_RSP;
                end
            end
            WR_RSP: begin
                if (rsp_valid_q && RSP_READY) begin
                    rsp_valid_d = 1'b0;
                    rsp_last_d  = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (beat_done) begin
            if (last_beat) begin
                if (rnw_q) begin
                    state_d = IDLE;
                end
            end else begin
                addr_d  = addr_q + STEP;
                cnt_d   = cnt_q - LEN_W'(1);
                state_d = rnw_q ? RD_ISSUE : WR_WAIT;
                if (rnw_q) begin
                    opb_addr_d = addr_q + STEP;
                end
            end
        end

        // Outputs are decoded from the next state so they line up with it.
        opb_re_d    = (state_d == RD_ISSUE);
        opb_we_d    = (state_d == WR_ISSUE);
        cmd_ready_d = (state_d == IDLE);
        wd_ready_d  = (state_d == WR_WAIT);
        busy_d      = (state_d != IDLE);
    end

    always_ff @(posedge OPB_CLK or negedge OPB_RST_N) begin
        if (!OPB_RST_N) begin
            state_q     <= IDLE;
            rnw_q       <= 1'b0;
            addr_q      <= '0;
            cnt_q       <= '0;
            opb_addr_q  <= '0;
            opb_di_q    <= '0;
            opb_re_q    <= 1'b0;
            opb_we_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_last_q  <= 1'b0;
            cmd_ready_q <= 1'b0;
            wd_ready_q  <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            rnw_q       <= rnw_d;
            addr_q      <= addr_d;
            cnt_q       <= cnt_d;
            opb_addr_q  <= opb_addr_d;
            opb_di_q    <= opb_di_d;
            opb_re_q    <= opb_re_d;
            opb_we_q    <= opb_we_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_last_q  <= rsp_last_d;
            cmd_ready_q <= cmd_ready_d;
            wd_ready_q  <= wd_ready_d;
            busy_q      <= busy_d;
        end
    end

    assign CMD_READY = cmd_ready_q;
    assign WD_READY  = wd_ready_q;
    assign RSP_VALID = rsp_valid_q;
    assign RSP_RDATA = rsp_rdata_q;
    assign RSP_LAST  = rsp_last_q;
    assign OPB_RE    = opb_re_q;
    assign OPB_WE    = opb_we_q;
    assign OPB_ADDR  = opb_addr_q;
    assign OPB_DI    = opb_di_q;
    assign BUSY      = busy_q;

endmodule

// File: tb/tb_opb_master.sv
// Directed bench for opb_master: single-beat vector table plus hand-written
// burst, stall, wrap and reset sequences against a simple decoder model.
module tb_opb_master;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid, cmd_ready, cmd_rnw;
    logic [31:0] cmd_addr;
    logic [7:0]  cmd_len;
    logic        wd_valid, wd_ready;
    logic [31:0] wd_data;
    logic        rsp_valid, rsp_ready, rsp_last;
    logic [31:0] rsp_rdata;
    logic        opb_re, opb_we;
    logic [31:0] opb_addr, opb_di, opb_do;
    logic        busy;

    always #5 clk = ~clk;

    opb_master #(.LEN_W(8), .ADDR_STEP(4)) dut (
        .OPB_CLK(clk), .OPB_RST_N(rst_n),
        .CMD_VALID(cmd_valid), .CMD_READY(cmd_ready), .CMD_RNW(cmd_rnw),
        .CMD_ADDR(cmd_addr), .CMD_LEN(cmd_len),
        .WD_VALID(wd_valid), .WD_READY(wd_ready), .WD_DATA(wd_data),
        .RSP_VALID(rsp_valid), .RSP_READY(rsp_ready), .RSP_RDATA(rsp_rdata),
        .RSP_LAST(rsp_last),
        .OPB_RE(opb_re), .OPB_WE(opb_we), .OPB_ADDR(opb_addr), .OPB_DI(opb_di),
        .OPB_DO(opb_do), .BUSY(busy)
    );

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    logic [31:0] re_addr_q[$];
    int          re_cyc_q[$];
    logic [31:0] we_addr_q[$];
    logic [31:0] we_di_q[$];
    logic        prev_re = 1'b0;
    logic        prev_we = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Decoder: read data appears the cycle after RE.
    function automatic logic [31:0] dec(input logic [31:0] a);
        return (a == 32'h0000_0100) ? 32'hDEAD_BEEF : (a ^ 32'hA5A5_0000);
    endfunction

    always @(posedge clk) if (opb_re) opb_do <= dec(opb_addr);

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_re = 1'b0;
            prev_we = 1'b0;
        end else begin
            n_cmp++;
            assert (!(opb_re && opb_we) && !(opb_re && prev_re) && !(opb_we && prev_we) &&
                    !(cmd_ready && busy) && !(opb_re && rsp_valid))
            else begin
                n_err++;
                $display("FAIL bus_rules cyc=%0d: re=%0b we=%0b prev_re=%0b prev_we=%0b cmd_ready=%0b busy=%0b rsp_valid=%0b (required no overlap, 1-cycle pulses, ready->!busy, no RE while rsp pending)",
                         cyc, opb_re, opb_we, prev_re, prev_we, cmd_ready, busy, rsp_valid);
            end
            if (opb_re) begin
                re_addr_q.push_back(opb_addr);
                re_cyc_q.push_back(cyc);
            end
            if (opb_we) begin
                we_addr_q.push_back(opb_addr);
                we_di_q.push_back(opb_di);
            end
            prev_re = opb_re;
            prev_we = opb_we;
        end
    end

    task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic sig(input int which);
        case (which)
            0:       return cmd_ready;
            1:       return wd_ready;
            default: return rsp_valid;
        endcase
    endfunction

    task automatic wait_for(input int which, input string name, output bit ok);
        int t = 0;
        while (sig(which) !== 1'b1 && t < 60) begin
            tick();
            t++;
        end
        ok = (sig(which) === 1'b1);
        if (!ok) begin
            n_cmp++;
            n_err++;
            $display("FAIL timeout_%s: got 0 after %0d cycles, required 1", name, t);
        end
    endtask

    task automatic send_cmd(input bit rnw, input logic [31:0] addr, input logic [7:0] len);
        bit ok;
        wait_for(0, "cmd_ready", ok);
        if (!ok) return;
        cmd_valid = 1'b1; cmd_rnw = rnw; cmd_addr = addr; cmd_len = len;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic send_wd(input logic [31:0] data, input int gap);
        bit ok;
        wait_for(1, "wd_ready", ok);
        if (!ok) return;
        repeat (gap) tick();
        wd_valid = 1'b1; wd_data = data;
        tick();
        wd_valid = 1'b0;
    endtask

    task automatic get_rsp(input int stall, output logic [31:0] rd, output logic last);
        bit ok;
        rd = '0; last = 1'b0;
        wait_for(2, "rsp_valid", ok);
        if (!ok) return;
        rd = rsp_rdata; last = rsp_last;
        for (int s = 0; s < stall; s++) begin
            tick();
            cmp("rsp_hold_valid", rsp_valid, 1'b1);
            cmp("rsp_hold_data", {rsp_last, rsp_rdata}, {last, rd});
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        cmp({tag, "_ctrl"}, {cmd_ready, wd_ready, rsp_valid, rsp_last, opb_re, opb_we, busy}, 0);
        cmp({tag, "_rdata"}, rsp_rdata, 0);
        cmp({tag, "_addr"}, opb_addr, 0);
        cmp({tag, "_di"}, opb_di, 0);
    endtask

    task automatic clear_logs();
        re_addr_q.delete(); re_cyc_q.delete(); we_addr_q.delete(); we_di_q.delete();
    endtask

    typedef struct {
        bit          rnw;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_addr;
        logic [31:0] exp_rdata;
        logic        exp_last;
    } vec_t;

    vec_t vecs[5];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [31:0] rd;
        logic        last;
        bit          ok;
        logic [31:0] exp_burst[4];
        logic [31:0] exp_wrap[2];

        vecs[0] = '{1'b1, 32'h0000_0100, 32'h0,         32'h0000_0100, 32'hDEAD_BEEF, 1'b1};
        vecs[1] = '{1'b1, 32'h1234_5678, 32'h0,         32'h1234_5678, 32'hB791_5678, 1'b1};
        vecs[2] = '{1'b0, 32'h0000_0040, 32'hCAFE_F00D, 32'h0000_0040, 32'h0,         1'b1};
        vecs[3] = '{1'b1, 32'hFFFF_FFFC, 32'h0,         32'hFFFF_FFFC, 32'h5A5A_FFFC, 1'b1};
        vecs[4] = '{1'b0, 32'h0000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0,         1'b1};
        exp_burst = '{32'hA5A5_0200, 32'hA5A5_0204, 32'hA5A5_0208, 32'hA5A5_020C};
        exp_wrap  = '{32'h5A5A_FFFC, 32'hA5A5_0000};

        rst_n = 1'b0;
        cmd_valid = 1'b0; cmd_rnw = 1'b0; cmd_addr = '0; cmd_len = '0;
        wd_valid = 1'b0; wd_data = '0; rsp_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst_n = 1'b1;
        tick();
        cmp("post_reset_cmd_ready", cmd_ready, 1'b1);
        cmp("post_reset_busy", busy, 1'b0);

        for (int i = 0; i < 5; i++) begin
            clear_logs();
            send_cmd(vecs[i].rnw, vecs[i].addr, 8'd0);
            if (!vecs[i].rnw) send_wd(vecs[i].wdata, 0);
            get_rsp(0, rd, last);
            cmp($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
            cmp($sformatf("vec%0d_last", i), last, vecs[i].exp_last);
            if (vecs[i].rnw) begin
                cmp($sformatf("vec%0d_re_count", i), re_addr_q.size(), 1);
                cmp($sformatf("vec%0d_we_count", i), we_addr_q.size(), 0);
                if (re_addr_q.size() > 0)
                    cmp($sformatf("vec%0d_re_addr", i), re_addr_q[0], vecs[i].exp_addr);
            end else begin
                cmp($sformatf("vec%0d_we_count", i), we_addr_q.size(), 1);
                cmp($sformatf("vec%0d_re_count", i), re_addr_q.size(), 0);
                if (we_addr_q.size() > 0) begin
                    cmp($sformatf("vec%0d_we_addr", i), we_addr_q[0], vecs[i].exp_addr);
                    cmp($sformatf("vec%0d_we_di", i), we_di_q[0], vecs[i].wdata);
                end
            end
            cmp($sformatf("vec%0d_idle", i), {cmd_ready, busy}, 2'b10);
        end

        // Read burst with a 5-cycle response stall on the first beat.
        clear_logs();
        send_cmd(1'b1, 32'h0000_0200, 8'd3);
        for (int b = 0; b < 4; b++) begin
            get_rsp((b == 0) ? 5 : 0, rd, last);
            cmp($sformatf("burst_rdata%0d", b), rd, exp_burst[b]);
            cmp($sformatf("burst_last%0d", b), last, (b == 3));
            cmp($sformatf("burst_re_count%0d", b), re_addr_q.size(), b + 1);
        end
        for (int b = 0; b < 4; b++)
            if (b < re_addr_q.size())
                cmp($sformatf("burst_re_addr%0d", b), re_addr_q[b], 32'h200 + 32'(4 * b));

        // Write burst with gapped write data.
        clear_logs();
        send_cmd(1'b0, 32'h0000_0300, 8'd1);
        send_wd(32'h11, 2);
        cmp("wr_no_early_rsp", rsp_valid, 1'b0);
        send_wd(32'h22, 2);
        get_rsp(0, rd, last);
        cmp("wr_rsp_rdata", rd, 0);
        cmp("wr_rsp_last", last, 1'b1);
        cmp("wr_we_count", we_addr_q.size(), 2);
        cmp("wr_re_count", re_addr_q.size(), 0);
        if (we_addr_q.size() == 2) begin
            cmp("wr_beat0", {we_addr_q[0], we_di_q[0]}, {32'h300, 32'h11});
            cmp("wr_beat1", {we_addr_q[1], we_di_q[1]}, {32'h304, 32'h22});
        end
        tick(); tick();
        cmp("wr_single_rsp", rsp_valid, 1'b0);

        // Address wrap and back-to-back read cadence.
        clear_logs();
        send_cmd(1'b1, 32'hFFFF_FFFC, 8'd1);
        for (int b = 0; b < 2; b++) begin
            get_rsp(0, rd, last);
            cmp($sformatf("wrap_rdata%0d", b), rd, exp_wrap[b]);
            cmp($sformatf("wrap_last%0d", b), last, (b == 1));
        end
        cmp("wrap_re_count", re_addr_q.size(), 2);
        if (re_addr_q.size() == 2) begin
            cmp("wrap_re_addr0", re_addr_q[0], 32'hFFFF_FFFC);
            cmp("wrap_re_addr1", re_addr_q[1], 32'h0000_0000);
            cmp("wrap_cadence", re_cyc_q[1] - re_cyc_q[0], 3);
        end

        // Reset while beat 2 of a 4-beat read is waiting for acceptance.
        clear_logs();
        send_cmd(1'b1, 32'h0000_0400, 8'd3);
        get_rsp(0, rd, last);
        wait_for(2, "rsp_valid_beat2", ok);
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("midreset");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        cmp("midreset_cmd_ready", cmd_ready, 1'b1);
        cmp("midreset_busy", busy, 1'b0);
        repeat (10) tick();
        cmp("midreset_no_more_re", re_addr_q.size(), 2);
        cmp("midreset_no_rsp", rsp_valid, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
